// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default widths, pointer sizing
// helper and the sticky error record.
package uart_pkg;

    localparam int DataLength = 8;
    localparam int FifoDepth  = 16;

    // One extra bit beyond the address width acts as the wrap bit, so full and
    // empty stay distinguishable when the address bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host buffer bus: write strobe from the UART receiver, FWFT read
// handshake towards the host, plus occupancy and error status.
interface uart_rx_fifo_if #(
    parameter int DataLength = uart_pkg::DataLength,
    parameter int Depth      = uart_pkg::FifoDepth
);
    import uart_pkg::*;

    logic [DataLength-1:0]       i_wr_data;
    logic                        i_wr_en;
    logic [DataLength-1:0]       o_rd_data;
    logic                        o_rd_valid;
    logic                        i_rd_en;
    logic [ptr_width(Depth)-1:0] o_count;
    logic                        o_full;
    logic                        o_almost_full;
    logic                        o_overflow;
    logic                        o_underflow;
    logic                        i_clr_err;

    modport master (
        output i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        input  o_rd_data, o_rd_valid, o_count, o_full, o_almost_full,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        output o_rd_data, o_rd_valid, o_count, o_full, o_almost_full,
               o_overflow, o_underflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Plain storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port, no reset and no control.
module uart_fifo_mem #(
    parameter int DataLength = 8,
    parameter int Depth      = 16,
    parameter int AddrW      = $clog2(Depth)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AddrW-1:0]      i_waddr,
    input  logic [DataLength-1:0] i_wdata,
    input  logic [AddrW-1:0]      i_raddr,
    output logic [DataLength-1:0] o_rdata
);
    import uart_pkg::*;

    logic [DataLength-1:0] mem_q [Depth];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with
// occupancy, almost-full warning and sticky overflow/underflow flags.
module uart_rx_fifo #(
    parameter int DataLength      = 8,
    parameter int Depth           = 16,
    parameter int AlmostFullLevel = 12
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    uart_rx_fifo_if.slave  bus
);
    import uart_pkg::*;

    localparam int PtrW  = ptr_width(Depth);
    localparam int AddrW = PtrW - 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    err_t            err_q, err_d;

    logic            empty, full, wr_ok, rd_ok;
    logic [PtrW-1:0] count;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        rd_ok    = bus.i_rd_en && !empty;
        wr_ok    = bus.i_wr_en && (!full || rd_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   wr_ptr_d = wr_ptr_q + PtrW'(1);
            2'b01:   rd_ptr_d = rd_ptr_q + PtrW'(1);
            2'b11: begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            default: ;
        endcase

        // Set has priority over clear so an error in the clearing cycle is kept.
        err_d.overflow  = (err_q.overflow  && !bus.i_clr_err) || (bus.i_wr_en && !wr_ok);
        err_d.underflow = (err_q.underflow && !bus.i_clr_err) || (bus.i_rd_en && empty);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    uart_fifo_mem #(
        .DataLength (DataLength),
        .Depth      (Depth),
        .AddrW      (AddrW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_ok),
        .i_waddr (wr_ptr_q[AddrW-1:0]),
        .i_wdata (bus.i_wr_data),
        .i_raddr (rd_ptr_q[AddrW-1:0]),
        .o_rdata (bus.o_rd_data)
    );

    assign bus.o_rd_valid    = !empty;
    assign bus.o_count       = count;
    assign bus.o_full        = full;
    assign bus.o_almost_full = (count >= PtrW'(AlmostFullLevel));
    assign bus.o_overflow    = err_q.overflow;
    assign bus.o_underflow   = err_q.underflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (Depth=4, AlmostFullLevel=3) against a
// queue-based reference model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] q [$];
    bit            m_ovf;
    bit            m_unf;

    uart_rx_fifo_if #(.DataLength(DW), .Depth(DEPTH)) bus ();

    uart_rx_fifo #(
        .DataLength      (DW),
        .Depth           (DEPTH),
        .AlmostFullLevel (AFL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances from the pre-edge state.
    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit pop, push;
        bus.i_wr_en   = wr;
        bus.i_wr_data = d;
        bus.i_rd_en   = rd;
        bus.i_clr_err = clr;
        pop   = rd && (q.size() > 0);
        push  = wr && ((q.size() < DEPTH) || pop);
        m_ovf = (m_ovf && !clr) || (wr && !push);
        m_unf = (m_unf && !clr) || (rd && (q.size() == 0));
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        @(posedge clk);
        #1;
        bus.i_wr_en   = 1'b0;
        bus.i_rd_en   = 1'b0;
        bus.i_clr_err = 1'b0;
        bus.i_wr_data = DW'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_clr_err = 1'b0; bus.i_wr_data = '0;
        q.delete(); m_ovf = 0; m_unf = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.o_rd_valid); end
        checks++; if (bus.o_count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.o_count); end
        checks++; if (bus.o_full !== 1'b0 || bus.o_almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_flags: got full=%0b af=%0b expected 0 0", bus.o_full, bus.o_almost_full); end
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_flags: got ovf=%0b unf=%0b expected 0 0", bus.o_overflow, bus.o_underflow); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cycle(1, 8'hA5, 0, 0);
        checks++; if (bus.o_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0b expected 1", bus.o_rd_valid); end
        checks++; if (bus.o_rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %0h expected a5", bus.o_rd_data); end
        checks++; if (bus.o_count !== CW'(1)) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", bus.o_count); end
        cycle(0, 8'h00, 1, 0);
        checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_count !== CW'(0)) begin errors++; $display("[TB] FAIL basic_pop: got valid=%0b count=%0d expected 0 0", bus.o_rd_valid, bus.o_count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            cycle(1, DW'(i), 0, 0);
            checks++; if (bus.o_almost_full !== (i >= AFL)) begin errors++; $display("[TB] FAIL fill_af_%0d: got %0b expected %0b", i, bus.o_almost_full, (i >= AFL)); end
            checks++; if (bus.o_full !== (i == DEPTH)) begin errors++; $display("[TB] FAIL fill_full_%0d: got %0b expected %0b", i, bus.o_full, (i == DEPTH)); end
        end
        cycle(1, 8'h05, 0, 0);
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow: got %0b expected 1", bus.o_overflow); end
        checks++; if (bus.o_count !== CW'(4)) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.o_count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== DW'(i)) begin errors++; $display("[TB] FAIL fill_drain_%0d: got valid=%0b data=%0h expected 1 %0h", i, bus.o_rd_valid, bus.o_rd_data, i); end
            cycle(0, 8'h00, 1, 0);
        end
        checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %0b expected 0", bus.o_rd_valid); end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 4; i++) cycle(1, DW'(8'h10 + i), 0, 0);
        cycle(1, 8'h14, 1, 0);
        checks++; if (bus.o_count !== CW'(4)) begin errors++; $display("[TB] FAIL pushpop_count: got %0d expected 4", bus.o_count); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overflow: got %0b expected 0", bus.o_overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.o_rd_data !== DW'(8'h10 + i)) begin errors++; $display("[TB] FAIL pushpop_drain_%0d: got %0h expected %0h", i, bus.o_rd_data, 8'h10 + i); end
            cycle(0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_errors();
        cycle(0, 8'h00, 1, 0);
        checks++; if (bus.o_underflow !== 1'b1) begin errors++; $display("[TB] FAIL err_underflow: got %0b expected 1", bus.o_underflow); end
        checks++; if (bus.o_count !== CW'(0) || bus.o_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_ptrs: got count=%0d valid=%0b expected 0 0", bus.o_count, bus.o_rd_valid); end
        for (int i = 0; i < 5; i++) cycle(1, DW'(8'h20 + i), 0, 0);
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL err_overflow: got %0b expected 1", bus.o_overflow); end
        cycle(0, 8'h00, 0, 1);
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got ovf=%0b unf=%0b expected 0 0", bus.o_overflow, bus.o_underflow); end
        cycle(1, 8'h2F, 0, 1);
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL err_set_wins: got %0b expected 1", bus.o_overflow); end
        checks++; if (bus.o_rd_data !== 8'h20) begin errors++; $display("[TB] FAIL err_head_kept: got %0h expected 20", bus.o_rd_data); end
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cycle(1, DW'(8'h30 + i), 0, 0);
            checks++; if (bus.o_rd_data !== DW'(8'h30 + i) || bus.o_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_data_%0d: got valid=%0b data=%0h expected 1 %0h", i, bus.o_rd_valid, bus.o_rd_data, 8'h30 + i); end
            checks++; if (bus.o_count > CW'(1)) begin errors++; $display("[TB] FAIL wrap_count_%0d: got %0d expected at most 1", i, bus.o_count); end
            cycle(0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1, DW'(8'h40 + i), 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 0; m_unf = 0;
        checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_count !== CW'(0)) begin errors++; $display("[TB] FAIL areset_now: got valid=%0b count=%0d expected 0 0", bus.o_rd_valid, bus.o_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 8'h5A, 0, 0);
        checks++; if (bus.o_rd_data !== 8'h5A || bus.o_count !== CW'(1)) begin errors++; $display("[TB] FAIL areset_after: got data=%0h count=%0d expected 5a 1", bus.o_rd_data, bus.o_count); end
        cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        int wr_pct;
        for (int n = 0; n < 400; n++) begin
            wr_pct = ((n / 50) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(0, 99) < wr_pct, DW'($urandom), $urandom_range(0, 99) < (100 - wr_pct), $urandom_range(0, 99) < 10);
            checks++; if (bus.o_count !== CW'(q.size())) begin errors++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", n, bus.o_count, q.size()); end
            checks++; if (bus.o_rd_valid !== (q.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid_%0d: got %0b expected %0b", n, bus.o_rd_valid, (q.size() != 0)); end
            if (q.size() != 0) begin
                checks++; if (bus.o_rd_data !== q[0]) begin errors++; $display("[TB] FAIL rand_data_%0d: got %0h expected %0h", n, bus.o_rd_data, q[0]); end
            end
            checks++; if (bus.o_full !== (q.size() == DEPTH) || bus.o_almost_full !== (q.size() >= AFL)) begin errors++; $display("[TB] FAIL rand_level_%0d: got full=%0b af=%0b expected %0b %0b", n, bus.o_full, bus.o_almost_full, (q.size() == DEPTH), (q.size() >= AFL)); end
            checks++; if (bus.o_overflow !== m_ovf || bus.o_underflow !== m_unf) begin errors++; $display("[TB] FAIL rand_err_%0d: got ovf=%0b unf=%0b expected %0b %0b", n, bus.o_overflow, bus.o_underflow, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_pushpop();
        test_errors();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
